// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus host-side console streams between a requester and mem_io_responder.
// Streams use valid/ready: a byte moves on a clock edge where valid and ready are both 1.
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        rdy_out;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output mem_a, mem_wr, mem_dout, rx_valid, rx_data, tx_ready,
        input  mem_din, rdy_out, rx_ready, tx_valid, tx_data
    );

    modport slave (
        input  mem_a, mem_wr, mem_dout, rx_valid, rx_data, tx_ready,
        output mem_din, rdy_out, rx_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus MMIO page (console FIFOs at 0x30000, cycle counter/stop at 0x30004).
// Define RX_BLOCK_EN to stall the CPU on a console read while the RX FIFO is empty.
module mem_io_responder #(
    parameter int ADDR_W  = 17,
    parameter int FIFO_AW = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mem_io_responder_if.slave bus,
    output logic              prog_stop,
    output logic              tx_ovf,
    output logic              state_dbg
);
    localparam int RAM_SIZE = 1 << ADDR_W;
    localparam int DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    logic [7:0]        ram [RAM_SIZE];
    logic [ADDR_W-1:0] ram_idx;
    logic [15:0]       io_off;
    logic              io;
    logic              rd_cyc, wr_cyc, waiting;
    logic              rx_rd, stop_wr, tx_req;
    logic              rx_push, rx_pop, tx_push, tx_pop;
    logic [7:0]        tx_in, rx_head;
    logic              rx_full, rx_empty, tx_full, tx_empty;
    logic [31:0]       counter, snap;
    logic              unused_addr;

    logic [7:0]         rx_mem [DEPTH];
    logic [FIFO_AW-1:0] rx_wp, rx_rp;
    logic [FIFO_AW:0]   rx_cnt;
    logic [7:0]         tx_mem [DEPTH];
    logic [FIFO_AW-1:0] tx_wp, tx_rp;
    logic [FIFO_AW:0]   tx_cnt;

    assign ram_idx     = bus.mem_a[ADDR_W-1:0];
    assign io_off      = bus.mem_a[15:0];
    assign io          = (bus.mem_a[17:16] == 2'b11);
    assign unused_addr = ^bus.mem_a[31:18];

`ifdef RX_BLOCK_EN
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state;

    // WAIT is left on the first cycle the RX FIFO holds a byte; that byte is popped then.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            bus.rdy_out <= 1'b1;
        end else begin
            case (state)
                IDLE: if (rx_rd && rx_empty) begin
                    state       <= WAIT;
                    bus.rdy_out <= 1'b0;
                end
                WAIT: if (!rx_empty) begin
                    state       <= IDLE;
                    bus.rdy_out <= 1'b1;
                end
            endcase
        end
    end
    assign waiting = (state == WAIT);
`else
    assign bus.rdy_out = 1'b1;
    assign waiting     = 1'b0;
`endif
    assign state_dbg = waiting;

    always_comb begin
        rd_cyc  = bus.rdy_out && !bus.mem_wr;
        wr_cyc  = bus.rdy_out && bus.mem_wr;
        rx_rd   = rd_cyc && io && (io_off == 16'h0000);
        stop_wr = wr_cyc && io && (io_off == 16'h0004);
        // The stop marker 0x00 bypasses the zero filter applied to console writes.
        tx_req  = stop_wr || (wr_cyc && io && (io_off == 16'h0000) && (bus.mem_dout != 8'h00));
        tx_in   = stop_wr ? 8'h00 : bus.mem_dout;
        tx_push = tx_req && !tx_full;
        tx_pop  = bus.tx_ready && !tx_empty;
        rx_push = bus.rx_valid && !rx_full;
        rx_pop  = (rx_rd || waiting) && !rx_empty;
    end

    assign rx_full      = (rx_cnt == FULL_CNT);
    assign rx_empty     = (rx_cnt == '0);
    assign rx_head      = rx_mem[rx_rp];
    assign bus.rx_ready = !rx_full;

    assign tx_full      = (tx_cnt == FULL_CNT);
    assign tx_empty     = (tx_cnt == '0);
    assign bus.tx_valid = !tx_empty;
    assign bus.tx_data  = tx_mem[tx_rp];

    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_wp] <= bus.rx_data;
        if (tx_push) tx_mem[tx_wp] <= tx_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CNT_ONE;
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CNT_ONE;
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CNT_ONE;
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CNT_ONE;
        end
    end

    // RAM is deliberately left out of reset; only the write of the reset cycle is blocked.
    always_ff @(posedge clk_in) begin
        if (!rst_in && wr_cyc && !io) ram[ram_idx] <= bus.mem_dout;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus.mem_din <= 8'h00;
            counter     <= '0;
            snap        <= '0;
            prog_stop   <= 1'b0;
            tx_ovf      <= 1'b0;
        end else begin
            counter <= counter + 32'd1;
            if (stop_wr) prog_stop <= 1'b1;
            if (tx_req && tx_full) tx_ovf <= 1'b1;
            if (waiting) begin
                if (!rx_empty) bus.mem_din <= rx_head;
            end else if (rd_cyc) begin
                if (!io) begin
                    bus.mem_din <= ram[ram_idx];
                end else begin
                    case (io_off)
                        16'h0000: begin
`ifdef RX_BLOCK_EN
                            if (!rx_empty) bus.mem_din <= rx_head;
`else
                            bus.mem_din <= rx_empty ? 8'h00 : rx_head;
`endif
                        end
                        // Only byte 0 latches, so a 4-byte read sequence sees one coherent value.
                        16'h0004: begin
                            snap        <= counter;
                            bus.mem_din <= counter[7:0];
                        end
                        16'h0005: bus.mem_din <= snap[15:8];
                        16'h0006: bus.mem_din <= snap[23:16];
                        16'h0007: bus.mem_din <= snap[31:24];
                        default:  bus.mem_din <= 8'h00;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: queue-based behavioural model checked every cycle,
// plus hand-computed expectations for RAM, console FIFOs, counter snapshot and reset.
module tb_mem_io_responder;
`ifdef RX_BLOCK_EN
    localparam bit BLOCK = 1'b1;
`else
    localparam bit BLOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic prog_stop, tx_ovf, state_dbg;
    int   n_chk = 0;
    int   n_err = 0;
    logic [31:0] exp_q[$];

    mem_io_responder_if bus();

    mem_io_responder #(.ADDR_W(17), .FIFO_AW(4)) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .bus       (bus),
        .prog_stop (prog_stop),
        .tx_ovf    (tx_ovf),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: RAM as an associative array, FIFOs as queues, counter as cycles since reset.
    logic [7:0]  m_ram [logic [16:0]];
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  m_din, tpush;
    logic        m_rdy, m_stop, m_ovf, tdo, mio;
    logic        m_valid = 1'b0;
    logic [31:0] m_cnt, m_snap;
    logic [15:0] off;
    logic [16:0] idx;
    int          rx_n0, tx_n0;

    always @(posedge clk) begin
        if (rst) begin
            m_din = 8'h00; m_rdy = 1'b1; m_stop = 1'b0; m_ovf = 1'b0;
            m_cnt = 32'd0; m_snap = 32'd0;
            rx_q.delete(); tx_q.delete();
            m_valid = 1'b1;
        end else if (m_valid) begin
            rx_n0 = rx_q.size(); tx_n0 = tx_q.size();
            tdo = 1'b0; tpush = 8'h00;
            mio = (bus.mem_a[17:16] == 2'b11);
            off = bus.mem_a[15:0];
            idx = bus.mem_a[16:0];
            if (!m_rdy) begin
                if (rx_n0 > 0) begin m_din = rx_q.pop_front(); m_rdy = 1'b1; end
            end else if (bus.mem_wr) begin
                if (!mio) m_ram[idx] = bus.mem_dout;
                else if (off == 16'h0 && bus.mem_dout != 8'h00) begin tdo = 1'b1; tpush = bus.mem_dout; end
                else if (off == 16'h4) begin m_stop = 1'b1; tdo = 1'b1; tpush = 8'h00; end
            end else if (!mio) begin
                m_din = m_ram.exists(idx) ? m_ram[idx] : 8'h00;
            end else if (off == 16'h0) begin
                if (rx_n0 > 0) m_din = rx_q.pop_front();
                else if (BLOCK) m_rdy = 1'b0;
                else m_din = 8'h00;
            end else if (off == 16'h4) begin
                m_snap = m_cnt; m_din = m_cnt[7:0];
            end else if (off >= 16'h5 && off <= 16'h7) begin
                m_din = 8'(m_snap >> (8 * (off - 16'h4)));
            end else begin
                m_din = 8'h00;
            end
            if (bus.tx_ready && tx_n0 > 0) void'(tx_q.pop_front());
            if (tdo) begin
                if (tx_n0 < 16) tx_q.push_back(tpush);
                else m_ovf = 1'b1;
            end
            if (bus.rx_valid && rx_n0 < 16) rx_q.push_back(bus.rx_data);
            m_cnt = m_cnt + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("mem_din",   bus.mem_din, m_din);
            check("rdy_out",   bus.rdy_out, m_rdy);
            check("state_dbg", state_dbg, !m_rdy);
            check("rx_ready",  bus.rx_ready, rx_q.size() < 16);
            check("tx_valid",  bus.tx_valid, tx_q.size() > 0);
            if (tx_q.size() > 0) check("tx_data", bus.tx_data, tx_q[0]);
            check("prog_stop", prog_stop, m_stop);
            check("tx_ovf",    tx_ovf, m_ovf);
        end
    end

    task automatic cycle(input logic [31:0] a, input logic wr, input logic [7:0] d);
        bus.mem_a = a; bus.mem_wr = wr; bus.mem_dout = d;
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(32'h30008, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        cycle(a, 1'b1, d);
    endtask

    task automatic rd(input logic [31:0] a);
        cycle(a, 1'b0, 8'h00);
    endtask

    task automatic rd_exp(input string name, input logic [31:0] a, input logic [7:0] e);
        exp_q.push_back({24'h0, e});
        rd(a);
        check(name, {24'h0, bus.mem_din}, exp_q.pop_front());
    endtask

    task automatic push_rx(input logic [7:0] b);
        bus.rx_valid = 1'b1; bus.rx_data = b;
        idle();
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_a = 32'h30008; bus.mem_wr = 1'b0; bus.mem_dout = 8'h00;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: no finish by %0t", $time);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        do_reset();
        check("rst_din", bus.mem_din, 8'h00);
        check("rst_rdy", bus.rdy_out, 1'b1);
        check("rst_tx_valid", bus.tx_valid, 1'b0);

        // Counter: the 101st cycle after reset sees counter == 100.
        repeat (100) idle();
        rd_exp("cnt_b0", 32'h30004, 8'h64);
        rd_exp("cnt_b1", 32'h30005, 8'h00);
        rd_exp("cnt_b2", 32'h30006, 8'h00);
        rd_exp("cnt_b3", 32'h30007, 8'h00);

        // RAM: read-after-write, top byte, bit-17 alias, IO writes leave RAM alone.
        wr(32'h00010, 8'hA5);
        rd_exp("raw_0x10", 32'h00010, 8'hA5);
        wr(32'h1FFFF, 8'h5A);
        rd_exp("ram_top", 32'h1FFFF, 8'h5A);
        rd_exp("ram_alias", 32'h20010, 8'hA5);
        wr(32'h10010, 8'h33);
        wr(32'h30010, 8'h77);
        rd_exp("io_other_rd", 32'h30010, 8'h00);
        rd_exp("io_wr_no_ram", 32'h10010, 8'h33);

        // Console RX.
        push_rx(8'h41);
        push_rx(8'h42);
        rd_exp("rx_first", 32'h30000, 8'h41);
        rd_exp("rx_second", 32'h30000, 8'h42);
        if (BLOCK) begin
            rd(32'h30000);
            check("rx_block_rdy", bus.rdy_out, 1'b0);
            repeat (3) @(negedge clk);
            check("rx_block_hold", bus.rdy_out, 1'b0);
            bus.rx_valid = 1'b1; bus.rx_data = 8'h43;
            @(negedge clk);
            bus.rx_valid = 1'b0;
            k = 0;
            while (bus.rdy_out !== 1'b1 && k < 10) begin @(negedge clk); k++; end
            check("rx_block_release", k < 10, 1'b1);
            check("rx_block_data", bus.mem_din, 8'h43);
        end else begin
            rd_exp("rx_empty", 32'h30000, 8'h00);
        end

        for (int i = 0; i < 16; i++) push_rx(8'(i + 1));
        check("rx_full_ready", bus.rx_ready, 1'b0);
        push_rx(8'h99);
        for (int i = 0; i < 16; i++) rd_exp("rx_fifo_order", 32'h30000, 8'(i + 1));
        check("rx_drained_ready", bus.rx_ready, 1'b1);

        // Console TX: zero filter, head stability, overflow.
        wr(32'h30000, 8'h48);
        wr(32'h30000, 8'h00);
        wr(32'h30000, 8'h49);
        check("tx_head0_valid", bus.tx_valid, 1'b1);
        check("tx_head0", bus.tx_data, 8'h48);
        bus.tx_ready = 1'b1; idle(); bus.tx_ready = 1'b0;
        check("tx_head1", bus.tx_data, 8'h49);
        bus.tx_ready = 1'b1; idle(); bus.tx_ready = 1'b0;
        check("tx_zero_dropped", bus.tx_valid, 1'b0);
        for (int i = 0; i < 16; i++) wr(32'h30000, 8'(8'h60 + i));
        check("tx_ovf_at_16", tx_ovf, 1'b0);
        wr(32'h30000, 8'h7F);
        check("tx_ovf_at_17", tx_ovf, 1'b1);
        check("tx_full_head", bus.tx_data, 8'h60);
        bus.tx_ready = 1'b1;
        k = 0;
        while (bus.tx_valid && k < 40) begin idle(); k++; end
        bus.tx_ready = 1'b0;
        check("tx_drain", bus.tx_valid, 1'b0);

        // Stop port.
        check("stop_before", prog_stop, 1'b0);
        wr(32'h30004, 8'hAB);
        check("stop_set", prog_stop, 1'b1);
        check("stop_marker_valid", bus.tx_valid, 1'b1);
        check("stop_marker", bus.tx_data, 8'h00);
        repeat (5) idle();
        check("stop_sticky", prog_stop, 1'b1);

        // Reset with traffic in flight.
        wr(32'h30000, 8'h55);
        if (BLOCK) begin
            rd(32'h30000);
            bus.rx_valid = 1'b1; bus.rx_data = 8'h44;
            @(negedge clk);
            bus.rx_valid = 1'b0;
            check("pre_rst_stalled", bus.rdy_out, 1'b0);
        end else begin
            push_rx(8'h44);
        end
        do_reset();
        check("post_rst_rdy", bus.rdy_out, 1'b1);
        check("post_rst_tx_valid", bus.tx_valid, 1'b0);
        check("post_rst_rx_ready", bus.rx_ready, 1'b1);
        check("post_rst_stop", prog_stop, 1'b0);
        check("post_rst_ovf", tx_ovf, 1'b0);
        repeat (5) idle();
        rd_exp("post_rst_cnt", 32'h30004, 8'h05);
        rd_exp("post_rst_ram", 32'h00010, 8'hA5);
        rd_exp("post_rst_rx_empty", 32'h30008, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
